// File: rtl/conv1d_stream_pkg.sv
// conv1d_stream_pkg
// Shared definitions for the streaming 1-D convolution engine:
//   - `WIDTH_DATA  default signed sample/weight/bias width (8 unless predefined)
//   - acc_width()  derives the full-precision accumulator width
//   - state_e      FSM encoding (IDLE=0, READY=1, ROW=2, DRAIN=3)
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package conv1d_stream_pkg;

  localparam int DATA_W = `WIDTH_DATA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_ROW   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // K products of 2*dw bits plus the bias; the extra clog2(K+1) bits
  // absorb the carries so the sum can never overflow.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/conv1d_stream_if.sv
// conv1d_stream_if
// Sample-in / result-out stream bundle of conv1d_stream.
//   x_valid/x_ready/x_data/x_last : sample stream into the engine
//   y_valid/y_ready/y_data        : result stream out of the engine
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// Once valid is high the sender holds valid and its data stable until the
// transfer; ready may change freely and never depends on valid.
// Modports: master = sample source / result sink, slave = the engine.
interface conv1d_stream_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
);
  logic                    x_valid;
  logic                    x_ready;
  logic signed [DW-1:0]    x_data;
  logic                    x_last;
  logic                    y_valid;
  logic                    y_ready;
  logic signed [ACC_W-1:0] y_data;

  modport master (
    output x_valid, x_data, x_last, y_ready,
    input  x_ready, y_valid, y_data
  );

  modport slave (
    input  x_valid, x_data, x_last, y_ready,
    output x_ready, y_valid, y_data
  );
endinterface

// File: rtl/conv1d_mac_tree.sv
// conv1d_mac_tree
// Two-stage registered multiply / adder tree.
//   Stage 1: K signed DW x DW products (2*DW bits each) plus the bias.
//   Stage 2: sign-extended sum of products and bias at ACC_W bits.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   stall_i       freezes both stages (downstream holding a result)
//   in_valid_i    window_i holds a window to be emitted
//   window_i      K taps, tap j at [j*DW +: DW], tap 0 oldest
//   weights_i     K taps, tap j at [j*DW +: DW]
//   bias_i        signed bias
//   s1_valid_o    stage 1 occupied
//   y_valid_o     stage 2 occupied (result valid)
//   y_data_o      signed result
// Build option: CONV1D_RELU_EN clamps negative sums to 0 in stage 2.
module conv1d_mac_tree
  import conv1d_stream_pkg::*;
#(
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    in_valid_i,
  input  logic [K*DW-1:0]         window_i,
  input  logic [K*DW-1:0]         weights_i,
  input  logic signed [DW-1:0]    bias_i,
  output logic                    s1_valid_o,
  output logic                    y_valid_o,
  output logic signed [ACC_W-1:0] y_data_o
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0]    prod_d [K];
  logic signed [PW-1:0]    prod_q [K];
  logic signed [DW-1:0]    bias_q;
  logic                    s1_valid_q;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] y_q;
  logic                    y_valid_q;

  always_comb begin
    for (int j = 0; j < K; j++) begin
      prod_d[j] = PW'($signed(window_i[j*DW +: DW])) * PW'($signed(weights_i[j*DW +: DW]));
    end
  end

  always_comb begin
    sum_d = ACC_W'(bias_q);
    for (int j = 0; j < K; j++) begin
      sum_d = sum_d + ACC_W'(prod_q[j]);
    end
`ifdef CONV1D_RELU_EN
    if (sum_d[ACC_W-1]) sum_d = '0;
`endif
  end

  // Bias travels with the products so a sample accepted in the same cycle
  // as a weight load is computed entirely with the old coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < K; j++) prod_q[j] <= '0;
      bias_q     <= '0;
      s1_valid_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
    end else if (!stall_i) begin
      s1_valid_q <= in_valid_i;
      y_valid_q  <= s1_valid_q;
      if (in_valid_i) begin
        prod_q <= prod_d;
        bias_q <= bias_i;
      end
      if (s1_valid_q) y_q <= sum_d;
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign y_valid_o  = y_valid_q;
  assign y_data_o   = y_q;

endmodule

// File: rtl/conv1d_stream.sv
// conv1d_stream
// Streaming K-tap 1-D convolution with bias and output stride.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   w_load       load strobe for w_in / b_in (accepted when w_ready)
//   w_in         K signed weights, tap j at [j*DW +: DW], tap 0 = oldest
//   b_in         signed bias
//   w_ready      weight load is accepted this cycle (IDLE or READY)
//   s            sample/result stream (conv1d_stream_if, slave side)
//   row_done     one-cycle pulse once the last result of a row is taken
//   row_short    sticky: a row ended with fewer than K samples
//   dbg_state_o  current FSM state
// Build option: CONV1D_RELU_EN (see conv1d_mac_tree).
module conv1d_stream
  import conv1d_stream_pkg::*;
#(
  parameter int K      = 3,
  parameter int DW     = DATA_W,
  parameter int STRIDE = 1,
  localparam int ACC_W = acc_width(DW, K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_load,
  input  logic [K*DW-1:0] w_in,
  input  logic [DW-1:0]   b_in,
  output logic            w_ready,
  conv1d_stream_if.slave  s,
  output logic            row_done,
  output logic            row_short,
  output state_e          dbg_state_o
);

  localparam int CW = $clog2(K + STRIDE + 1);
  localparam int SW = $clog2(STRIDE + 1);

  state_e               state_q, state_d;
  logic [K*DW-1:0]      w_q, w_d;
  logic [DW-1:0]        b_q, b_d;
  logic [K*DW-1:0]      win_q, win_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SW-1:0]        sc_q, sc_d;
  logic                 row_short_q, row_short_d;

  logic                 s1_valid, y_valid;
  logic signed [ACC_W-1:0] y_data;
  logic                 stall, x_ready_w, accept, w_accept;
  logic                 eligible, emit, pipe_empty, load_state;

  assign stall      = y_valid && !s.y_ready;
  assign x_ready_w  = (state_q == ST_READY || state_q == ST_ROW) && !stall;
  assign accept     = s.x_valid && x_ready_w;
  assign load_state = (state_q == ST_IDLE || state_q == ST_READY);
  assign w_accept   = w_load && load_state;
  assign pipe_empty = !s1_valid && !y_valid;

  // Row-relative sample count, saturating so long rows cannot wrap.
  assign cnt_inc  = (cnt_q == CW'(K + STRIDE)) ? cnt_q : cnt_q + CW'(1);
  assign eligible = (cnt_inc >= CW'(K));
  // sc_q counts eligible samples modulo STRIDE; position 0 emits.
  assign emit     = accept && eligible && (sc_q == '0);

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    b_d         = b_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    sc_d        = sc_q;
    row_short_d = row_short_q;

    if (w_accept) begin
      w_d         = w_in;
      b_d         = b_in;
      row_short_d = 1'b0;
    end

    if (accept) begin
      // Newest sample enters at the top tap; tap 0 holds the oldest.
      win_d = {s.x_data, win_q[K*DW-1:DW]};
      cnt_d = cnt_inc;
      if (eligible) sc_d = (sc_q == SW'(STRIDE - 1)) ? '0 : sc_q + SW'(1);
    end

    case (state_q)
      ST_IDLE:  if (w_load) state_d = ST_READY;
      ST_READY: if (accept) state_d = s.x_last ? ST_DRAIN : ST_ROW;
      ST_ROW:   if (accept && s.x_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_READY;
          win_d   = '0;
          cnt_d   = '0;
          sc_d    = '0;
          if (cnt_q < CW'(K)) row_short_d = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      b_q         <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      sc_q        <= '0;
      row_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      b_q         <= b_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      sc_q        <= sc_d;
      row_short_q <= row_short_d;
    end
  end

  conv1d_mac_tree #(
    .K     (K),
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .in_valid_i (emit),
    .window_i   (win_d),
    .weights_i  (w_q),
    .bias_i     (b_q),
    .s1_valid_o (s1_valid),
    .y_valid_o  (y_valid),
    .y_data_o   (y_data)
  );

  // w_ready is forced low while rst is held so every output reads 0 in reset.
  assign w_ready     = load_state && !rst;
  assign s.x_ready   = x_ready_w;
  assign s.y_valid   = y_valid;
  assign s.y_data    = y_data;
  assign row_done    = (state_q == ST_DRAIN) && pipe_empty;
  assign row_short   = row_short_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv1d_stream.sv
module tb_conv1d_stream;
  import conv1d_stream_pkg::*;

  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int ACC_W = acc_width(DW, K);

`ifdef CONV1D_RELU_EN
  localparam int NEG300 = 0;
`else
  localparam int NEG300 = -300;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic            w_load = 1'b0;
  logic [K*DW-1:0] w_in = '0;
  logic [DW-1:0]   b_in = '0;
  logic            w_ready, w_ready2;
  logic            row_done, row_short, row_done2, row_short2;
  state_e          dbg_state, dbg_state2;

  conv1d_stream_if #(.DW(DW), .ACC_W(ACC_W)) ifc ();
  conv1d_stream_if #(.DW(DW), .ACC_W(ACC_W)) ifc2 ();

  conv1d_stream #(.K(K), .DW(DW), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .b_in(b_in),
    .w_ready(w_ready), .s(ifc), .row_done(row_done), .row_short(row_short),
    .dbg_state_o(dbg_state)
  );

  // Stride-2 instance shares the sample stream and always accepts results.
  assign ifc2.x_valid = ifc.x_valid;
  assign ifc2.x_data  = ifc.x_data;
  assign ifc2.x_last  = ifc.x_last;
  assign ifc2.y_ready = 1'b1;

  conv1d_stream #(.K(K), .DW(DW), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .b_in(b_in),
    .w_ready(w_ready2), .s(ifc2), .row_done(row_done2), .row_short(row_short2),
    .dbg_state_o(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] got2_q[$];
  logic [ACC_W-1:0] e;
  int rd_cnt = 0, rd2_cnt = 0;
  bit yv_seen = 1'b0;
  int first_yv_cyc = 0;
  int acc_cyc[5];

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.y_valid && !yv_seen) begin
        yv_seen = 1'b1;
        first_yv_cyc = cyc;
      end
      if (ifc.y_valid && ifc.y_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL y_unexpected: got %0d, no result expected", $signed(ifc.y_data));
        end else begin
          e = exp_q.pop_front();
          check("y_data", longint'($signed(ifc.y_data)), longint'($signed(e)));
        end
      end
      if (row_done)     rd_cnt++;
      if (row_done2)    rd2_cnt++;
      if (ifc2.y_valid) got2_q.push_back(ifc2.y_data);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic load_w(input logic [K*DW-1:0] w, input int b);
    w_load = 1'b1;
    w_in   = w;
    b_in   = DW'(b);
    @(negedge clk);
    check("w_ready_on_load", w_ready, 1);
    @(posedge clk); #1;
    w_load = 1'b0;
  endtask

  task automatic send_row(input logic [5*DW-1:0] xs, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      int tmo;
      bit acc;
      ifc.x_valid = 1'b1;
      ifc.x_data  = xs[i*DW +: DW];
      ifc.x_last  = last_at_end && (i == n - 1);
      acc = 1'b0;
      tmo = 0;
      while (!acc && tmo < 200) begin
        @(negedge clk);
        if (ifc.x_ready) begin
          acc = 1'b1;
          acc_cyc[i] = cyc;
        end else begin
          tmo++;
        end
        @(posedge clk); #1;
      end
      check("x_accept", acc, 1);
    end
    ifc.x_valid = 1'b0;
    ifc.x_last  = 1'b0;
  endtask

  task automatic wait_row_end(input int rd0);
    int tmo = 0;
    while (rd_cnt == rd0 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    repeat (4) @(negedge clk);
    check("row_done_pulses", rd_cnt - rd0, 1);
    @(posedge clk); #1;
  endtask

  task automatic bp_ctl(input longint first_y);
    int tmo = 0;
    @(negedge clk);
    while (!ifc.y_valid && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check("bp_y_valid_seen", ifc.y_valid, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_x_ready_low", ifc.x_ready, 0);
      check("bp_y_hold", longint'($signed(ifc.y_data)), first_y);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    ifc.y_ready = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3*DW-1:0]    w;
    int                 b;
    logic [5*DW-1:0]    x;
    int                 n;
    int                 n_exp;
    logic [3*ACC_W-1:0] y;
    bit                 short_exp;
    bit                 bp;
  } vec_t;

  function automatic logic [3*DW-1:0] pk3(input int a, input int b, input int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [5*DW-1:0] pk5(input int a, input int b, input int c,
                                          input int d, input int f);
    return {DW'(f), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [3*ACC_W-1:0] pky(input int a, input int b, input int c);
    return {ACC_W'(c), ACC_W'(b), ACC_W'(a)};
  endfunction

  vec_t vecs[6];

  initial begin
    int rd0;
    int rd2_0;

    vecs[0] = '{pk3(1, 2, 3), 10, pk5(1, 2, 3, 4, 5), 5, 3, pky(24, 30, 36), 1'b0, 1'b0};
    vecs[1] = '{pk3(1, 2, 3), 10, pk5(1, 2, 3, 4, 5), 5, 3, pky(24, 30, 36), 1'b0, 1'b1};
    vecs[2] = '{pk3(-128, -128, -128), 127, pk5(-128, -128, -128, 0, 0), 3, 1,
                pky(49279, 0, 0), 1'b0, 1'b0};
    vecs[3] = '{pk3(-1, -1, -1), 0, pk5(100, 100, 100, 0, 0), 3, 1,
                pky(NEG300, 0, 0), 1'b0, 1'b0};
    vecs[4] = '{pk3(0, 0, 1), -5, pk5(4, -3, 8, 6, 0), 4, 2, pky(3, 1, 0), 1'b0, 1'b0};
    vecs[5] = '{pk3(1, 2, 3), 10, pk5(7, 9, 0, 0, 0), 2, 0, pky(0, 0, 0), 1'b1, 1'b0};

    ifc.x_valid = 1'b0;
    ifc.x_data  = '0;
    ifc.x_last  = 1'b0;
    ifc.y_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_w_ready", w_ready, 0);
    check("rst_x_ready", ifc.x_ready, 0);
    check("rst_y_valid", ifc.y_valid, 0);
    check("rst_y_data", ifc.y_data, 0);
    check("rst_row_done", row_done, 0);
    check("rst_row_short", row_short, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, ST_IDLE);
    check("idle_x_ready", ifc.x_ready, 0);
    check("idle_w_ready", w_ready, 1);
    @(posedge clk); #1;

    // Table-driven rows
    for (int i = 0; i < 6; i++) begin
      load_w(vecs[i].w, vecs[i].b);
      check("load_clears_short", row_short, 0);
      for (int j = 0; j < vecs[i].n_exp; j++) exp_q.push_back(vecs[i].y[j*ACC_W +: ACC_W]);
      rd0   = rd_cnt;
      rd2_0 = rd2_cnt;
      yv_seen = 1'b0;
      got2_q.delete();
      if (vecs[i].bp) begin
        ifc.y_ready = 1'b0;
        fork
          send_row(vecs[i].x, vecs[i].n, 1'b1);
          bp_ctl(longint'($signed(vecs[i].y[ACC_W-1:0])));
        join
      end else begin
        send_row(vecs[i].x, vecs[i].n, 1'b1);
      end
      wait_row_end(rd0);
      check("row_short", row_short, vecs[i].short_exp);
      check("exp_q_drained", exp_q.size(), 0);
      check("state_ready_after_row", dbg_state, ST_READY);
      if (i == 0) begin
        check("latency", first_yv_cyc - acc_cyc[2], 2);
        check("stride2_count", got2_q.size(), 2);
        if (got2_q.size() == 2) begin
          check("stride2_y0", longint'($signed(got2_q[0])), 24);
          check("stride2_y1", longint'($signed(got2_q[1])), 36);
        end
        check("stride2_row_done", rd2_cnt - rd2_0, 1);
      end
      if (i == 5) check("short_no_y", yv_seen, 0);
    end

    // Subsequent w_load clears row_short
    load_w(pk3(1, 2, 3), 10);
    check("short_cleared", row_short, 0);

    // w_load in ROW is ignored
    exp_q.push_back(ACC_W'(24));
    exp_q.push_back(ACC_W'(30));
    exp_q.push_back(ACC_W'(36));
    rd0 = rd_cnt;
    send_row(pk5(1, 2, 0, 0, 0), 2, 1'b0);
    w_load = 1'b1;
    w_in   = pk3(5, 5, 5);
    b_in   = '0;
    @(negedge clk);
    check("row_w_ready", w_ready, 0);
    check("row_state", dbg_state, ST_ROW);
    @(posedge clk); #1;
    w_load = 1'b0;
    send_row(pk5(3, 4, 5, 0, 0), 3, 1'b1);
    wait_row_end(rd0);
    check("old_weights_drained", exp_q.size(), 0);

    // Asynchronous reset mid-row with a result held by backpressure
    ifc.y_ready = 1'b0;
    send_row(pk5(1, 2, 3, 0, 0), 3, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_y_valid", ifc.y_valid, 1);
    check("pre_rst_y_data", longint'($signed(ifc.y_data)), 24);
    rd0 = rd_cnt;
    #2 rst = 1'b1;
    #1;
    check("arst_y_valid", ifc.y_valid, 0);
    check("arst_y_data", ifc.y_data, 0);
    check("arst_x_ready", ifc.x_ready, 0);
    check("arst_w_ready", w_ready, 0);
    check("arst_row_done", row_done, 0);
    check("arst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.y_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_x_ready", ifc.x_ready, 0);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_no_row_done", rd_cnt - rd0, 0);
    @(posedge clk); #1;
    load_w(pk3(1, 2, 3), 10);
    @(negedge clk);
    check("reload_x_ready", ifc.x_ready, 1);
    @(posedge clk); #1;

    // Recovery: exact-K row emits exactly one result
    exp_q.push_back(ACC_W'(24));
    rd0 = rd_cnt;
    send_row(pk5(1, 2, 3, 0, 0), 3, 1'b1);
    wait_row_end(rd0);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 300000);
    $fatal(1, "watchdog");
  end

endmodule
